// File: rtl/mem_stage.sv
// Memory pipeline stage: holds one instruction, waits for load data, and extends it.
// Optional MEM_FWD_DATA_EN forwards final_result (including same-cycle load data) to decode.
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        ws_allowin,
  output logic        ms_allowin,
  input  logic        es_to_ms_valid,
  input  logic [75:0] es_to_ms_bus,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  output logic        ms_to_ws_valid,
  output logic [69:0] ms_to_ws_bus,
  output logic [39:0] ms_fwd_bus
);

  // state   | meaning
  // S_EMPTY | no instruction held (ms_valid=0)
  // S_WAIT  | load held, response not yet seen
  // S_READY | instruction held, result available
  typedef enum logic [1:0] {S_EMPTY, S_WAIT, S_READY} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [75:0] r_bus;
  logic [31:0] r_buf_data;
  logic        r_buf_valid;

  logic        w_ms_valid;
  logic        w_wait;
  logic        w_ready_go;
  logic        w_accept;
  logic [4:0]  w_ld_op;
  logic        w_res_from_mem;
  logic        w_gr_we;
  logic [4:0]  w_dest;
  logic [31:0] w_alu_result;
  logic [31:0] w_pc;
  logic [31:0] w_raw;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;
  logic [31:0] w_final_result;
  logic        w_fwd_we;
  logic [31:0] w_fwd_data;

  assign {w_ld_op, w_res_from_mem, w_gr_we, w_dest, w_alu_result, w_pc} = r_bus;

  assign w_ms_valid     = (r_state != S_EMPTY);
  assign w_wait         = (r_state == S_WAIT);
  assign w_ready_go     = !w_wait || data_sram_data_ok;
  assign ms_allowin     = !w_ms_valid || (w_ready_go && ws_allowin);
  assign ms_to_ws_valid = w_ms_valid && w_ready_go;
  assign w_accept       = es_to_ms_valid && ms_allowin;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_EMPTY;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (ms_allowin) begin
      if (es_to_ms_valid) w_state_nxt = es_to_ms_bus[70] ? S_WAIT : S_READY;
      else                w_state_nxt = S_EMPTY;
    end else if (w_wait && data_sram_data_ok) begin
      w_state_nxt = S_READY;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_bus <= es_to_ms_bus;
  end

  // Response arrived but downstream is stalled: keep the word until we can leave.
  always_ff @(posedge clk) begin
    if (reset)                                  r_buf_valid <= 1'b0;
    else if (ms_allowin)                        r_buf_valid <= 1'b0;
    else if (w_wait && data_sram_data_ok)       r_buf_valid <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!ms_allowin && w_wait && data_sram_data_ok) r_buf_data <= data_sram_rdata;
  end

  assign w_raw  = r_buf_valid ? r_buf_data : data_sram_rdata;
  assign w_half = w_alu_result[1] ? w_raw[31:16] : w_raw[15:0];

  always_comb begin
    case (w_alu_result[1:0])
      2'd0:    w_byte = w_raw[7:0];
      2'd1:    w_byte = w_raw[15:8];
      2'd2:    w_byte = w_raw[23:16];
      default: w_byte = w_raw[31:24];
    endcase
  end

  always_comb begin
    w_load_data = w_raw;
    if (w_ld_op[4])      w_load_data = {{24{w_byte[7]}}, w_byte};
    else if (w_ld_op[3]) w_load_data = {24'd0, w_byte};
    else if (w_ld_op[2]) w_load_data = {{16{w_half[15]}}, w_half};
    else if (w_ld_op[1]) w_load_data = {16'd0, w_half};
  end

  assign w_final_result = w_res_from_mem ? w_load_data : w_alu_result;
  assign ms_to_ws_bus   = {w_gr_we, w_dest, w_final_result, w_pc};

`ifdef MEM_FWD_DATA_EN
  assign w_fwd_we   = w_ms_valid && w_gr_we && (w_dest != 5'd0);
  assign w_fwd_data = w_final_result;
`else
  // Without a data path, only settled non-load results may be claimed as forwardable.
  assign w_fwd_we   = w_ms_valid && w_gr_we && (w_dest != 5'd0)
                      && (r_state == S_READY) && !w_res_from_mem;
  assign w_fwd_data = 32'd0;
`endif

  assign ms_fwd_bus = {w_ms_valid, w_fwd_we, w_wait && !data_sram_data_ok, w_dest, w_fwd_data};

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: vector table for extension/pass-through plus
// hand sequences for stall buffering, reset-abandoned loads and back-to-back flow.
module tb_mem_stage;

`ifdef MEM_FWD_DATA_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        ws_allowin;
  logic        ms_allowin;
  logic        es_to_ms_valid;
  logic [75:0] es_to_ms_bus;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        ms_to_ws_valid;
  logic [69:0] ms_to_ws_bus;
  logic [39:0] ms_fwd_bus;

  int n_checks = 0;
  int n_fail   = 0;

  mem_stage dut (
    .clk              (clk),
    .reset            (reset),
    .ws_allowin       (ws_allowin),
    .ms_allowin       (ms_allowin),
    .es_to_ms_valid   (es_to_ms_valid),
    .es_to_ms_bus     (es_to_ms_bus),
    .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata  (data_sram_rdata),
    .ms_to_ws_valid   (ms_to_ws_valid),
    .ms_to_ws_bus     (ms_to_ws_bus),
    .ms_fwd_bus       (ms_fwd_bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  ld_op;
    logic        res;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu;
    logic [31:0] pc;
    logic [31:0] rdata;
    logic [31:0] exp_res;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [75:0] mk_bus(input vec_t v);
    return {v.ld_op, v.res, v.gr_we, v.dest, v.alu, v.pc};
  endfunction

  function automatic logic [75:0] nl_bus(input logic [4:0] dest, input logic [31:0] alu,
                                         input logic [31:0] pc);
    return {5'b0, 1'b0, 1'b1, dest, alu, pc};
  endfunction

  initial begin
    logic        we;
    logic [75:0] b;
    vecs[0] = '{5'b00000, 1'b0, 1'b1, 5'd5,  32'h1234_5678, 32'h1c00_0000, 32'h0,         32'h1234_5678};
    vecs[1] = '{5'b10000, 1'b1, 1'b1, 5'd7,  32'h0000_1003, 32'h1c00_0004, 32'h80FF_0000, 32'hFFFF_FF80};
    vecs[2] = '{5'b01000, 1'b1, 1'b1, 5'd7,  32'h0000_1003, 32'h1c00_0008, 32'h80FF_0000, 32'h0000_0080};
    vecs[3] = '{5'b00100, 1'b1, 1'b1, 5'd9,  32'h0000_2002, 32'h1c00_000c, 32'h8001_1234, 32'hFFFF_8001};
    vecs[4] = '{5'b00010, 1'b1, 1'b1, 5'd9,  32'h0000_2000, 32'h1c00_0010, 32'h8001_1234, 32'h0000_1234};
    vecs[5] = '{5'b00001, 1'b1, 1'b1, 5'd3,  32'h0000_3000, 32'h1c00_0014, 32'hCAFE_F00D, 32'hCAFE_F00D};
    vecs[6] = '{5'b10000, 1'b1, 1'b1, 5'd4,  32'h0000_4001, 32'h1c00_0018, 32'h0000_7F00, 32'h0000_007F};
    vecs[7] = '{5'b00000, 1'b0, 1'b1, 5'd0,  32'hA5A5_0001, 32'h1c00_001c, 32'h0,         32'hA5A5_0001};

    reset = 1'b1; ws_allowin = 1'b1; es_to_ms_valid = 1'b0; es_to_ms_bus = '0;
    data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_valid",   ms_to_ws_valid, 0);
    check("rst_allowin", ms_allowin, 1);
    check("rst_fwd_top", ms_fwd_bus[39:37], 0);

    // Table vectors: accept, optional data_ok, deliver, confirm empty.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      es_to_ms_valid = 1'b1; es_to_ms_bus = mk_bus(vecs[i]); ws_allowin = 1'b1;
      @(negedge clk);
      es_to_ms_valid = 1'b0;
      we = vecs[i].gr_we && (vecs[i].dest != 0);
      if (vecs[i].res) begin
        #1;
        check("ld_wait_valid", ms_to_ws_valid, 0);
        check("ld_wait_fwd", ms_fwd_bus[39:32], {1'b1, FWD & we, 1'b1, vecs[i].dest});
        data_sram_data_ok = 1'b1; data_sram_rdata = vecs[i].rdata;
        #1;
        check("ld_dok_fwd", ms_fwd_bus,
              {1'b1, FWD & we, 1'b0, vecs[i].dest, FWD ? vecs[i].exp_res : 32'h0});
      end else begin
        #1;
        check("nl_fwd", ms_fwd_bus,
              {1'b1, we, 1'b0, vecs[i].dest, FWD ? vecs[i].alu : 32'h0});
      end
      check("vec_valid", ms_to_ws_valid, 1);
      check("vec_bus", ms_to_ws_bus, {vecs[i].gr_we, vecs[i].dest, vecs[i].exp_res, vecs[i].pc});
      @(negedge clk);
      data_sram_data_ok = 1'b0;
      #1;
      check("vec_drained", {ms_to_ws_valid, ms_allowin}, 2'b01);
    end

    // Stalled downstream: data_ok once, held in buffer, delivered once on release.
    @(negedge clk);
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = {5'b00001, 1'b1, 1'b1, 5'd6, 32'h0000_0100, 32'h1c00_0100};
    @(negedge clk);
    es_to_ms_valid = 1'b0; ws_allowin = 1'b0;
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'hDEAD_BEEF;
    #1;
    check("stall_allowin0", ms_allowin, 0);
    check("stall_valid0", ms_to_ws_valid, 1);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      data_sram_data_ok = 1'b0; data_sram_rdata = 32'h1111_1111;
      #1;
      check("stall_allowin", ms_allowin, 0);
      check("stall_bus", ms_to_ws_bus, {1'b1, 5'd6, 32'hDEAD_BEEF, 32'h1c00_0100});
    end
    @(negedge clk);
    ws_allowin = 1'b1;
    #1;
    check("release_valid", ms_to_ws_valid, 1);
    check("release_bus", ms_to_ws_bus, {1'b1, 5'd6, 32'hDEAD_BEEF, 32'h1c00_0100});
    check("release_allowin", ms_allowin, 1);
    @(negedge clk);
    #1;
    check("release_once", ms_to_ws_valid, 0);

    // Reset abandons a waiting load; a late data_ok must be ignored.
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = {5'b00001, 1'b1, 1'b1, 5'd8, 32'h0000_0200, 32'h1c00_0200};
    @(negedge clk);
    es_to_ms_valid = 1'b0;
    #1;
    check("pre_rst_pending", ms_fwd_bus[39:37], {1'b1, 1'b0 | FWD, 1'b1});
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_rst", {ms_to_ws_valid, ms_allowin, ms_fwd_bus[39:37]}, 5'b01000);
    @(negedge clk);
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h5555_5555;
    #1;
    check("stale_dok_valid", ms_to_ws_valid, 0);
    @(negedge clk);
    data_sram_data_ok = 1'b0;
    #1;
    check("stale_dok_empty", {ms_to_ws_valid, ms_allowin, ms_fwd_bus[39:37]}, 5'b01000);

    // Back-to-back non-loads with a stray data_ok: one per cycle, no bubbles.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      b = nl_bus(5'(i + 10), 32'h7000_0000 + 32'(i), 32'h1c00_0300 + 32'(4 * i));
      data_sram_data_ok = (i == 2); data_sram_rdata = 32'hFFFF_FFFF;
      if (i > 0) begin
        #1;
        check("b2b_valid", ms_to_ws_valid, 1);
        check("b2b_allowin", ms_allowin, 1);
        check("b2b_bus", ms_to_ws_bus,
              {1'b1, 5'(i + 9), 32'h7000_0000 + 32'(i - 1), 32'h1c00_0300 + 32'(4 * (i - 1))});
        check("b2b_fwd", ms_fwd_bus[31:0], FWD ? 32'h7000_0000 + 32'(i - 1) : 32'h0);
      end
      es_to_ms_valid = (i < 4); es_to_ms_bus = b;
    end
    data_sram_data_ok = 1'b0;
    @(negedge clk);
    #1;
    check("b2b_drained", ms_to_ws_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
